// File: rtl/counter_checker.sv
// ----------------------------------------------------------------------------
// counter_checker
// Lock-step checker for an up/down/load counter. A golden model of the
// counter runs on the same reset/enable/mode/D inputs as the counter under
// test. Once armed by the first reset, every non-reset edge compares the
// counter outputs against the model state registered on the previous edge.
// The checker keeps a sticky error flag, a per-mismatch pulse, and
// saturating mismatch and compare counters.
//
// Optional feature: define ERROR_CAPTURE_EN to latch the expected Q, the
// counter Q and the compare index at the first mismatch after arming.
// Without it, the capture outputs are tied to zero.
// ----------------------------------------------------------------------------
module counter_checker #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] dut_q,
    input  logic             dut_rco,
    input  logic             dut_load,
    output logic             error,
    output logic             err_pulse,
    output logic [15:0]      err_count,
    output logic [15:0]      check_count,
    output logic [WIDTH-1:0] cap_q_exp,
    output logic [WIDTH-1:0] cap_q_dut,
    output logic [15:0]      cap_idx
);

    localparam logic [1:0]  MODE_UP3  = 2'b00;
    localparam logic [1:0]  MODE_DN1  = 2'b01;
    localparam logic [1:0]  MODE_UP1  = 2'b10;
    localparam logic [1:0]  MODE_LOAD = 2'b11;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // Golden model state
    logic [WIDTH-1:0] r_m_q;
    logic             r_m_rco;
    logic             r_m_load;

    // Checker state. Armed and the pulse start low at power-up so that no
    // compare can happen and no pulse can appear before the first reset.
    logic             r_armed     = 1'b0;
    logic             r_err_pulse = 1'b0;
    logic             r_error;
    logic [15:0]      r_err_count;
    logic [15:0]      r_check_count;

    // Model next-state values
    logic [WIDTH-1:0] w_m_q_next;
    logic             w_m_rco_next;
    logic             w_m_load_next;

    // Carry-extended sums so the ripple carry falls out of the top bit
    logic [WIDTH:0]   w_sum3;
    logic [WIDTH:0]   w_sum1;

    logic             w_compare;
    logic             w_mismatch;

    assign w_sum3 = {1'b0, r_m_q} + (WIDTH+1)'(3);
    assign w_sum1 = {1'b0, r_m_q} + (WIDTH+1)'(1);

    // Compare only after arming and never on a reset edge
    assign w_compare  = r_armed & ~reset;
    assign w_mismatch = ({dut_q, dut_rco, dut_load} != {r_m_q, r_m_rco, r_m_load});

    // Model next state: enable low holds Q and drops the strobes, otherwise
    // the selected mode decides Q, carry and load indication
    always_comb begin
        w_m_q_next    = r_m_q;
        w_m_rco_next  = 1'b0;
        w_m_load_next = 1'b0;
        if (enable) begin
            case (mode)
                MODE_UP3: begin
                    w_m_q_next   = w_sum3[WIDTH-1:0];
                    w_m_rco_next = w_sum3[WIDTH];
                end
                MODE_DN1: begin
                    w_m_q_next   = r_m_q - WIDTH'(1);
                    w_m_rco_next = (r_m_q == '0);
                end
                MODE_UP1: begin
                    w_m_q_next   = w_sum1[WIDTH-1:0];
                    w_m_rco_next = w_sum1[WIDTH];
                end
                MODE_LOAD: begin
                    w_m_q_next    = D;
                    w_m_load_next = 1'b1;
                end
                default: begin
                    w_m_q_next = r_m_q;
                end
            endcase
        end
    end

    // Golden model registers: every reset (first or later) zeroes them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_q    <= '0;
            r_m_rco  <= 1'b0;
            r_m_load <= 1'b0;
        end else begin
            r_m_q    <= w_m_q_next;
            r_m_rco  <= w_m_rco_next;
            r_m_load <= w_m_load_next;
        end
    end

    // Arming, compare counters, sticky error and per-mismatch pulse.
    // Only the arming reset clears the history; later resets only drop the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_pulse <= 1'b0;
            if (!r_armed) begin
                r_armed       <= 1'b1;
                r_error       <= 1'b0;
                r_err_count   <= '0;
                r_check_count <= '0;
            end
        end else if (w_compare) begin
            if (r_check_count != CNT_MAX) begin
                r_check_count <= r_check_count + 16'd1;
            end
            r_err_pulse <= w_mismatch;
            if (w_mismatch) begin
                r_error <= 1'b1;
                if (r_err_count != CNT_MAX) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end else begin
            r_err_pulse <= 1'b0;
        end
    end

`ifdef ERROR_CAPTURE_EN
    logic             r_captured;
    logic [WIDTH-1:0] r_cap_q_exp;
    logic [WIDTH-1:0] r_cap_q_dut;
    logic [15:0]      r_cap_idx;

    // First-mismatch snapshot; held until the arming reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            if (!r_armed) begin
                r_captured  <= 1'b0;
                r_cap_q_exp <= '0;
                r_cap_q_dut <= '0;
                r_cap_idx   <= '0;
            end
        end else if (w_compare && w_mismatch && !r_captured) begin
            r_captured  <= 1'b1;
            r_cap_q_exp <= r_m_q;
            r_cap_q_dut <= dut_q;
            r_cap_idx   <= r_check_count;
        end
    end

    assign cap_q_exp = r_cap_q_exp;
    assign cap_q_dut = r_cap_q_dut;
    assign cap_idx   = r_cap_idx;
`else
    assign cap_q_exp = '0;
    assign cap_q_dut = '0;
    assign cap_idx   = '0;
`endif

    assign error       = r_error;
    assign err_pulse   = r_err_pulse;
    assign err_count   = r_err_count;
    assign check_count = r_check_count;

endmodule

// File: tb/tb_counter_checker.sv
// ----------------------------------------------------------------------------
// tb_counter_checker
// Drives the checker with an ideal counter computed in plain integer
// arithmetic, optionally corrupting the counter outputs, and predicts the
// checker status (pulse, sticky flag, counts, first-mismatch capture).
// Honours ERROR_CAPTURE_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_counter_checker;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] D = '0;
    logic [W-1:0] dut_q = '0;
    logic         dut_rco = 1'b0;
    logic         dut_load = 1'b0;
    logic         error;
    logic         err_pulse;
    logic [15:0]  err_count;
    logic [15:0]  check_count;
    logic [W-1:0] cap_q_exp;
    logic [W-1:0] cap_q_dut;
    logic [15:0]  cap_idx;

    counter_checker #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .D           (D),
        .dut_q       (dut_q),
        .dut_rco     (dut_rco),
        .dut_load    (dut_load),
        .error       (error),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .check_count (check_count),
        .cap_q_exp   (cap_q_exp),
        .cap_q_dut   (cap_q_dut),
        .cap_idx     (cap_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Ideal counter state (value after the most recent edge)
    int b_q = 0;
    int b_rco = 0;
    int b_load = 0;

    // Predicted checker status
    int b_armed = 0;
    int b_err = 0;
    int b_pulse = 0;
    int b_errs = 0;
    int b_checks = 0;
    int b_captured = 0;
    int b_cap_exp = 0;
    int b_cap_dut = 0;
    int b_cap_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("err_pulse", {31'b0, err_pulse}, b_pulse);
        if (b_armed != 0) begin
            chk("error", {31'b0, error}, b_err);
            chk("err_count", {16'b0, err_count}, b_errs);
            chk("check_count", {16'b0, check_count}, b_checks);
`ifdef ERROR_CAPTURE_EN
            chk("cap_q_exp", {28'b0, cap_q_exp}, b_cap_exp);
            chk("cap_q_dut", {28'b0, cap_q_dut}, b_cap_dut);
            chk("cap_idx", {16'b0, cap_idx}, b_cap_idx);
`else
            chk("cap_q_exp", {28'b0, cap_q_exp}, 0);
            chk("cap_q_dut", {28'b0, cap_q_dut}, 0);
            chk("cap_idx", {16'b0, cap_idx}, 0);
`endif
        end
    endtask

    // One clock: present inputs plus the (possibly corrupted) counter
    // outputs, predict the effect of the edge, then check after it.
    // mask[3:0] flips Q bits, mask[4] flips the carry.
    task automatic cyc(input int r, input int e, input int m, input int d, input logic [4:0] mask);
        int nq;
        int mism;
        reset    = r[0];
        enable   = e[0];
        mode     = m[1:0];
        D        = d[W-1:0];
        dut_q    = W'(b_q) ^ mask[3:0];
        dut_rco  = b_rco[0] ^ mask[4];
        dut_load = b_load[0];
        mism     = (mask != 5'b0);
        @(posedge clk);
        if (r != 0) begin
            if (b_armed == 0) begin
                b_armed = 1; b_err = 0; b_errs = 0; b_checks = 0;
                b_captured = 0; b_cap_exp = 0; b_cap_dut = 0; b_cap_idx = 0;
            end
            b_pulse = 0;
            b_q = 0; b_rco = 0; b_load = 0;
        end else begin
            if (b_armed != 0) begin
                if (mism != 0) begin
                    if (b_captured == 0) begin
                        b_captured = 1;
                        b_cap_exp  = b_q;
                        b_cap_dut  = int'(W'(b_q) ^ mask[3:0]);
                        b_cap_idx  = b_checks;
                    end
                    b_err = 1;
                    b_pulse = 1;
                    if (b_errs < 65535) b_errs++;
                end else begin
                    b_pulse = 0;
                end
                if (b_checks < 65535) b_checks++;
            end else begin
                b_pulse = 0;
            end
            b_load = 0;
            b_rco  = 0;
            if (e != 0) begin
                case (m)
                    0: begin nq = b_q + 3;       b_rco = (nq >= MOD) ? 1 : 0; b_q = nq % MOD; end
                    1: begin b_rco = (b_q == 0) ? 1 : 0; b_q = (b_q + MOD - 1) % MOD; end
                    2: begin nq = b_q + 1;       b_rco = (nq >= MOD) ? 1 : 0; b_q = nq % MOD; end
                    default: begin b_q = d % MOD; b_load = 1; end
                endcase
            end
        end
        #1;
        check_all();
    endtask

    int saved;

    initial begin
        // Before arming: mismatching counter outputs must not pulse
        cyc(0, 1, 0, 0, 5'h1F);
        cyc(0, 1, 2, 0, 5'h05);

        // Two reset cycles arm the checker and clear everything
        cyc(1, 0, 0, 0, 5'h00);
        cyc(1, 0, 0, 0, 5'h00);
        chk("reset_check_count", {16'b0, check_count}, 0);
        chk("reset_error", {31'b0, error}, 0);

        // Count by three: 0,3,6,9,12,15,2 compared, carry on 2
        repeat (7) cyc(0, 1, 0, 0, 5'h00);
        chk("up3_check_count", {16'b0, check_count}, 7);
        chk("up3_error", {31'b0, error}, 0);

        // Later reset keeps the counts; count down wraps 0 -> 15 with carry
        cyc(1, 1, 0, 0, 5'h00);
        chk("rst2_check_count", {16'b0, check_count}, 7);
        repeat (3) cyc(0, 1, 1, 0, 5'h00);
        chk("dn1_err_pulse", {31'b0, err_pulse}, 0);
        chk("dn1_err_count", {16'b0, err_count}, 0);

        // Load A, counter answers B
        cyc(0, 1, 3, 'hA, 5'h00);
        cyc(0, 1, 3, 'hA, 5'h01);
        chk("load_err_pulse", {31'b0, err_pulse}, 1);
        chk("load_err_count", {16'b0, err_count}, 1);
        chk("load_error", {31'b0, error}, 1);
`ifdef ERROR_CAPTURE_EN
        chk("load_cap_exp", {28'b0, cap_q_exp}, 'hA);
        chk("load_cap_dut", {28'b0, cap_q_dut}, 'hB);
`endif
        cyc(0, 1, 3, 'hA, 5'h00);
        chk("pulse_one_cycle", {31'b0, err_pulse}, 0);

        // Hold at 7 with enable low; compares continue
        cyc(0, 1, 3, 7, 5'h00);
        saved = int'(check_count);
        repeat (3) cyc(0, 0, 0, 0, 5'h00);
        chk("hold_q", b_q, 7);
        chk("hold_check_count", {16'b0, check_count}, saved + 3);

        // Mid-run reset keeps error history, no compare on the reset edge
        saved = int'(check_count);
        cyc(1, 1, 0, 0, 5'h00);
        chk("midrst_err_count", {16'b0, err_count}, 1);
        chk("midrst_error", {31'b0, error}, 1);
        chk("midrst_check_count", {16'b0, check_count}, saved);

        // Random traffic with occasional resets and corrupted outputs
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [4:0] mk;
            r  = ($urandom_range(0, 31) == 0) ? 1 : 0;
            mk = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'h00;
            cyc(r, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, MOD - 1), mk);
            $display("step %0d rst=%0d en=%0d mode=%0d D=%0h q=%0h pulse=%0d errs=%0d checks=%0d",
                     i, reset, enable, mode, D, dut_q, err_pulse, err_count, check_count);
        end

        // Saturation: enough forced mismatches to pin both counters
        repeat (65540) cyc(0, 1, 2, 0, 5'h02);
        chk("sat_err_count", {16'b0, err_count}, 'hFFFF);
        chk("sat_err_pulse", {31'b0, err_pulse}, 1);
        chk("sat_check_count", {16'b0, check_count}, 'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
